// File: rtl/treasure_scheduler_pkg.sv
// treasure_scheduler_pkg: FSM encoding and colour/shape codes shared with the image processor
package treasure_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, REPORT} state_t;
  localparam logic [1:0] NONE     = 2'b00;
  localparam logic [1:0] RED      = 2'b01;
  localparam logic [1:0] BLUE     = 2'b10;
  localparam logic [1:0] TRIANGLE = 2'b11;
  localparam logic [1:0] SQUARE   = 2'b10;
  localparam logic [1:0] DIAMOND  = 2'b01;
  function automatic logic is_hit(input logic [1:0] colour, input logic [1:0] shape);
    return colour != NONE && shape != NONE;
  endfunction
endpackage

// File: rtl/treasure_scheduler_frame_tick.sv
// frame_tick: one-cycle SAMPLE pulse, one cycle after the VSYNC falling edge is seen
module frame_tick (
  input  logic CLK,
  input  logic RESET,
  input  logic VGA_VSYNC_NEG,
  output logic SAMPLE
);
  logic vs_q, sample_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      vs_q     <= 1'b1;
      sample_q <= 1'b0;
    end else begin
      vs_q     <= VGA_VSYNC_NEG;
      sample_q <= vs_q & ~VGA_VSYNC_NEG;
    end
  assign SAMPLE = sample_q;
endmodule

// File: rtl/treasure_scheduler.sv
// treasure_scheduler: declares a treasure once NEED_FRAMES consecutive frames agree on a colour/shape
module treasure_scheduler
  import treasure_scheduler_pkg::*;
#(
  parameter int NEED_FRAMES = 3,
  parameter int MAX_FRAMES  = 12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ACK,
  input  logic       VGA_VSYNC_NEG,
  input  logic [1:0] RESULT,
  input  logic [1:0] SHAPE,
  output logic       BUSY,
  output logic       VALID,
  output logic [1:0] TREASURE_COLOR,
  output logic [1:0] TREASURE_SHAPE
);
  localparam logic [3:0] NEED_L = 4'(NEED_FRAMES);
  localparam logic [3:0] MAX_L  = 4'(MAX_FRAMES);
  state_t     state_q, state_d;
  logic [3:0] frame_cnt_q, frame_cnt_d, streak_q, streak_d, prev_q, prev_d;
  logic [3:0] code, cnt_inc, streak_inc;
  logic [1:0] colour_q, colour_d, shape_q, shape_d;
  logic       busy_q, valid_q, sample, hit;
  frame_tick u_tick (
    .CLK          (CLK),
    .RESET        (RESET),
    .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
    .SAMPLE       (sample)
  );
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    streak_d    = streak_q;
    prev_d      = prev_q;
    colour_d    = colour_q;
    shape_d     = shape_q;
    code        = {RESULT, SHAPE};
    hit         = is_hit(RESULT, SHAPE);
    cnt_inc     = (frame_cnt_q == 4'hF) ? frame_cnt_q : frame_cnt_q + 4'd1;
    streak_inc  = !hit ? 4'd0 : (code == prev_q) ? streak_q + 4'd1 : 4'd1;
    case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        streak_d    = '0;
        prev_d      = '0;
        if (START) state_d = SKIP;
      end
      SKIP: if (sample) state_d = COLLECT;
      COLLECT: if (sample) begin
        frame_cnt_d = cnt_inc;
        streak_d    = streak_inc;
        prev_d      = code;
        // a completed streak takes priority over the frame budget running out
        if (streak_inc == NEED_L) begin
          state_d  = REPORT;
          colour_d = RESULT;
          shape_d  = SHAPE;
        end else if (cnt_inc == MAX_L) begin
          state_d  = REPORT;
          colour_d = NONE;
          shape_d  = NONE;
        end
      end
      REPORT: if (ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      streak_q    <= '0;
      prev_q      <= '0;
      colour_q    <= NONE;
      shape_q     <= NONE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      streak_q    <= streak_d;
      prev_q      <= prev_d;
      colour_q    <= colour_d;
      shape_q     <= shape_d;
      busy_q      <= state_d != IDLE;
      valid_q     <= state_d == REPORT;
    end
  assign BUSY           = busy_q;
  assign VALID          = valid_q;
  assign TREASURE_COLOR = colour_q;
  assign TREASURE_SHAPE = shape_q;
endmodule

// File: tb/tb_treasure_scheduler.sv
// tb_treasure_scheduler: scenario tasks with a scoreboard of expected treasure codes
module tb_treasure_scheduler;
  import treasure_scheduler_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0, vs = 1'b1;
  logic [1:0] result = 2'b00, shape = 2'b00;
  logic busy, valid, busy2, valid2;
  logic [1:0] tcol, tshp, tcol2, tshp2;
  logic v1, v2, w1, w2;
  logic [3:0] fr [16];
  logic [3:0] sb [$];
  int tests = 0, fails = 0;
  localparam logic [3:0] RS = {RED, SQUARE}, RT = {RED, TRIANGLE}, BT = {BLUE, TRIANGLE};
  localparam logic [3:0] BD = {BLUE, DIAMOND}, BS = {BLUE, SQUARE}, NN = {NONE, NONE};
  always #5 clk = ~clk;
  treasure_scheduler dut (
    .CLK(clk), .RESET(rst), .START(start), .ACK(ack), .VGA_VSYNC_NEG(vs),
    .RESULT(result), .SHAPE(shape), .BUSY(busy), .VALID(valid),
    .TREASURE_COLOR(tcol), .TREASURE_SHAPE(tshp)
  );
  treasure_scheduler #(.NEED_FRAMES(3), .MAX_FRAMES(3)) dut_min (
    .CLK(clk), .RESET(rst), .START(start), .ACK(ack), .VGA_VSYNC_NEG(vs),
    .RESULT(result), .SHAPE(shape), .BUSY(busy2), .VALID(valid2),
    .TREASURE_COLOR(tcol2), .TREASURE_SHAPE(tshp2)
  );
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    vs = 1'b1;
    {result, shape} = NN;
    start = 1'b0;
    ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  // VSYNC falls at negedge n; VALID may rise only after negedge n+1, visible at n+2
  task automatic gen_frame(input logic [3:0] code);
    @(negedge clk) vs = 1'b1;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    {result, shape} = code;
    @(negedge clk) begin v1 = valid; w1 = valid2; end
    @(negedge clk) begin v2 = valid; w2 = valid2; end
    @(negedge clk);
  endtask
  task automatic wait_result(input string name);
    int n;
    logic [3:0] exp, got;
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!valid) begin
      fails++;
      $display("FAIL %s timeout: VALID=%b required 1", name, valid);
      return;
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard empty: got %b required an entry", name, {tcol, tshp});
      return;
    end
    exp = sb.pop_front();
    got = {tcol, tshp};
    tests++;
    if (got !== exp || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s result: code=%b busy=%b required code=%b busy=1", name, got, busy, exp);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({tcol, tshp} !== exp || valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s hold: code=%b valid=%b busy=%b required %b/1/1", name, {tcol, tshp}, valid, busy, exp);
    end
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || {tcol, tshp} !== exp) begin
      fails++;
      $display("FAIL %s after ack: valid=%b busy=%b code=%b required 0/0/%b", name, valid, busy, {tcol, tshp}, exp);
    end
  endtask
  task automatic run_frames(input string name, input int n, input logic [3:0] exp);
    sb.push_back(exp);
    for (int i = 0; i < n; i++) begin
      gen_frame(fr[i]);
      tests++;
      if (i < n - 1 && v2 !== 1'b0) begin
        fails++;
        $display("FAIL %s early report at frame %0d: VALID=%b required 0", name, i, v2);
      end else if (i == n - 1 && (v1 !== 1'b0 || v2 !== 1'b1)) begin
        fails++;
        $display("FAIL %s valid latency: +1=%b +2=%b required 0 then 1", name, v1, v2);
      end
    end
    wait_result(name);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, valid, tcol, tshp} !== 6'b0) begin
      fails++;
      $display("FAIL reset_state: busy/valid/code=%b required 000000", {busy, valid, tcol, tshp});
    end
    rst = 1'b0;
    gen_frame(RS);
    gen_frame(RS);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL no_start_run: busy=%b valid=%b required 0/0", busy, valid);
    end
    pulse_start();
    for (int i = 0; i < 4; i++) gen_frame(BT);
    tests++;
    if (valid !== 1'b1 || {tcol, tshp} !== BT) begin
      fails++;
      $display("FAIL pre_async_reset: valid=%b code=%b required 1/%b", valid, {tcol, tshp}, BT);
    end
    @(negedge clk) rst = 1'b1;
    #1;
    tests++;
    if ({busy, valid, tcol, tshp} !== 6'b0) begin
      fails++;
      $display("FAIL async_reset: busy/valid/code=%b required 000000", {busy, valid, tcol, tshp});
    end
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_red_square();
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) fr[i] = RS;
    run_frames("red_square", 4, RS);
  endtask
  task automatic test_no_treasure();
    do_reset();
    pulse_start();
    fr[0] = BT;
    for (int i = 1; i <= 12; i++) fr[i] = (i % 2) ? BT : BD;
    run_frames("no_treasure", 13, NN);
  endtask
  task automatic test_streak_reset();
    do_reset();
    pulse_start();
    fr[0] = RT; fr[1] = RT; fr[2] = RT; fr[3] = NN;
    fr[4] = RT; fr[5] = RT; fr[6] = RT;
    run_frames("streak_reset", 7, RT);
  endtask
  task automatic test_need_eq_max();
    logic [3:0] exp;
    do_reset();
    pulse_start();
    sb.push_back(BS);
    for (int i = 0; i < 4; i++) begin
      gen_frame(BS);
      tests++;
      if (i < 3 && w2 !== 1'b0) begin
        fails++;
        $display("FAIL need_eq_max early at frame %0d: VALID=%b required 0", i, w2);
      end else if (i == 3 && (w1 !== 1'b0 || w2 !== 1'b1)) begin
        fails++;
        $display("FAIL need_eq_max latency: +1=%b +2=%b required 0 then 1", w1, w2);
      end
    end
    exp = sb.pop_front();
    tests++;
    if ({tcol2, tshp2} !== exp) begin
      fails++;
      $display("FAIL need_eq_max code: got %b required %b", {tcol2, tshp2}, exp);
    end
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask
  task automatic test_mid_reset();
    do_reset();
    pulse_start();
    gen_frame(RS);
    gen_frame(RS);
    gen_frame(RS);
    tests++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset pre: busy=%b valid=%b required 1/0", busy, valid);
    end
    @(negedge clk) rst = 1'b1;
    #1;
    tests++;
    if ({busy, valid, tcol, tshp} !== 6'b0) begin
      fails++;
      $display("FAIL mid_reset async: busy/valid/code=%b required 000000", {busy, valid, tcol, tshp});
    end
    @(negedge clk) rst = 1'b0;
    gen_frame(RS);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset idle: busy=%b required 0", busy);
    end
    pulse_start();
    for (int i = 0; i < 4; i++) fr[i] = RS;
    run_frames("mid_reset_rerun", 4, RS);
  endtask
  task automatic test_ignore();
    logic [3:0] exp;
    do_reset();
    pulse_start();
    sb.push_back(RT);
    gen_frame(RT);
    gen_frame(RT);
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    pulse_start();
    gen_frame(RT);
    gen_frame(RT);
    exp = sb.pop_front();
    tests++;
    if (v2 !== 1'b1 || {tcol, tshp} !== exp) begin
      fails++;
      $display("FAIL ignore_run: valid=%b code=%b required 1/%b", v2, {tcol, tshp}, exp);
    end
    @(negedge clk) begin start = 1'b1; ack = 1'b1; end
    @(negedge clk) begin start = 1'b0; ack = 1'b0; end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || {tcol, tshp} !== exp) begin
      fails++;
      $display("FAIL start_ack_idle: busy=%b valid=%b code=%b required 0/0/%b", busy, valid, {tcol, tshp}, exp);
    end
    gen_frame(RT);
    gen_frame(RT);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL stays_idle: busy=%b valid=%b required 0/0", busy, valid);
    end
  endtask
  initial begin
    test_reset();
    test_red_square();
    test_no_treasure();
    test_streak_reset();
    test_need_eq_max();
    test_mid_reset();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
